ps2_word_receiver: RTL

Parametrised PS/2 device-to-host receiver. It samples the raw keyboard clock and data lines and filters the clock. It deserialises the 11-bit frames, checks each one, and assembles NBYTES consecutive valid bytes into one word. This is the successor to the fixed 4-byte PS/2 top. It sits between the PS/2 pins and the scan-code decode/display logic, and adds frame validation, a watchdog timeout and a configurable word length.

---
 rtl/ps2_word_receiver.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ps2_word_receiver.sv
// PS/2 device-to-host receiver: synchronise, filter ps2c, deserialise and check 11-bit
// frames, and pack NBYTES valid bytes into one word. Define PS2_PARITY_CHECK_EN to reject bad parity.
module ps2_word_receiver #(
    parameter int unsigned NBYTES      = 4,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ps2d,
    input  logic                         ps2c,
    input  logic                         rx_en,
    output logic [7:0]                   byte_out,
    output logic                         byte_tick,
    output logic [8*NBYTES-1:0]          word_out,
    output logic                         listo,
    output logic [$clog2(NBYTES+1)-1:0]  byte_cnt,
    output logic                         frame_err,
    output logic                         parity_err
);

    localparam int unsigned CW = $clog2(NBYTES + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned AW = 8 * NBYTES;

    typedef enum logic [1:0] {StIdle, StData, StCheck} state_e;

    logic [1:0]            ps2c_sync_q;
    logic [1:0]            ps2d_sync_q;
    logic [FILTER_LEN-1:0] taps_q;
    logic                  filt_q;
    logic                  fall_tick;

    state_e          state_q;
    logic [3:0]      bit_cnt_q;
    logic [10:0]     frame_q;
    logic [WW-1:0]   wdog_q;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_next;
    logic            frame_ok;
    logic            par_bad;
    logic            word_done;

    // Synchronisers and filter idle high so reset release never looks like a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2c_sync_q <= 2'b11;
            ps2d_sync_q <= 2'b11;
            taps_q      <= '1;
            filt_q      <= 1'b1;
        end else begin
            ps2c_sync_q <= {ps2c_sync_q[0], ps2c};
            ps2d_sync_q <= {ps2d_sync_q[0], ps2d};
            taps_q      <= {taps_q[FILTER_LEN-2:0], ps2c_sync_q[1]};
            if (taps_q == '0) begin
                filt_q <= 1'b0;
            end else if (&taps_q) begin
                filt_q <= 1'b1;
            end
        end
    end

    assign fall_tick = filt_q & (taps_q == '0);

    // frame_q = {stop, parity, d7..d0, start}
    always_comb begin
        frame_ok  = ~frame_q[0] & frame_q[10];
        word_done = (byte_cnt == CW'(NBYTES - 1));
        acc_next  = acc_q << 8;
        acc_next[7:0] = frame_q[8:1];
    end

`ifdef PS2_PARITY_CHECK_EN
    assign par_bad = ~(^frame_q[9:1]);
`else
    logic unused_parity;
    assign unused_parity = frame_q[9];
    assign par_bad       = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            wdog_q     <= '0;
            acc_q      <= '0;
            byte_out   <= '0;
            byte_tick  <= 1'b0;
            word_out   <= '0;
            listo      <= 1'b0;
            byte_cnt   <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            byte_tick  <= 1'b0;
            listo      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (fall_tick && rx_en) begin
                        frame_q   <= {ps2d_sync_q[1], frame_q[10:1]};
                        bit_cnt_q <= 4'd10;
                        wdog_q    <= '0;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (!rx_en) begin
                        state_q <= StIdle;
                    end else if (fall_tick) begin
                        frame_q   <= {ps2d_sync_q[1], frame_q[10:1]};
                        bit_cnt_q <= bit_cnt_q - 4'd1;
                        wdog_q    <= '0;
                        if (bit_cnt_q == 4'd1) begin
                            state_q <= StCheck;
                        end
                    end else if (wdog_q == WW'(TIMEOUT_CYC - 1)) begin
                        frame_err <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                StCheck: begin
                    state_q <= StIdle;
                    if (!frame_ok) begin
                        frame_err <= 1'b1;
                    end else if (par_bad) begin
                        parity_err <= 1'b1;
                    end else begin
                        byte_out  <= frame_q[8:1];
                        byte_tick <= 1'b1;
                        acc_q     <= acc_next;
                        if (word_done) begin
                            word_out <= acc_next;
                            listo    <= 1'b1;
                            byte_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
